dpram_fifo_ctrl: RTL

//  - Single-clock FIFO controller that sits directly upstream of the 8-bit dual-port RAM.
//    It drives the RAM address, write-data and write-enable pins and consumes the RAM's

---
 rtl/dpram_fifo_pkg.sv | 19 +
 rtl/dpram_fifo_ptr.sv | 41 ++++
 rtl/dpram_fifo_ctrl.sv | 97 +++++++++
 3 files changed

// File: rtl/dpram_fifo_pkg.sv
// ============================================================================
// dpram_fifo_pkg : shared widths and types for the dual-port-RAM FIFO controller
// Rev 1.0
// ============================================================================
`default_nettype none

package dpram_fifo_pkg;

    localparam int AW    = 8;
    localparam int DW    = 8;
    localparam int DEPTH = 2 ** AW;

    typedef logic [AW-1:0] addr_t;
    typedef logic [DW-1:0] data_t;
    typedef logic [AW:0]   lvl_t;

endpackage

`default_nettype wire

// File: rtl/dpram_fifo_ptr.sv
// ============================================================================
// dpram_fifo_ptr : wrapping RAM pointer plus occupancy counter (cnt' = cnt+inc-dec)
// Rev 1.0
// ============================================================================
`default_nettype none

module dpram_fifo_ptr
    import dpram_fifo_pkg::*;
#(
    parameter bit PTR_ON_INC = 1'b1    // 1: pointer follows inc, 0: pointer follows dec
) (
    input  logic  clk,
    input  logic  rst_n,
    input  logic  inc,
    input  logic  dec,
    output addr_t ptr,
    output lvl_t  cnt
);

    addr_t r_ptr;
    lvl_t  r_cnt;
    logic  w_adv;

    assign w_adv = PTR_ON_INC ? inc : dec;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr <= '0;
            r_cnt <= '0;
        end else begin
            r_ptr <= r_ptr + addr_t'(w_adv);
            r_cnt <= r_cnt + lvl_t'(inc) - lvl_t'(dec);
        end
    end

    assign ptr = r_ptr;
    assign cnt = r_cnt;

endmodule

`default_nettype wire

// File: rtl/dpram_fifo_ctrl.sv
// ============================================================================
// dpram_fifo_ctrl : single-clock FIFO controller driving an 8-bit dual-port RAM
// Optional sticky overflow/underflow flags: define DPRAM_FIFO_CTRL_ERR_EN
// Rev 1.0
// ============================================================================
`default_nettype none

module dpram_fifo_ctrl
    import dpram_fifo_pkg::*;
(
    input  logic  clk,
    input  logic  rst_n,
`ifdef DPRAM_FIFO_CTRL_ERR_EN
    input  logic  err_clr,
    output logic  ovf_err,
    output logic  udf_err,
`endif
    input  logic  wr_valid,
    output logic  wr_ready,
    input  data_t wr_data,
    output logic  rd_valid,
    input  logic  rd_ready,
    output data_t rd_data,
    output lvl_t  level,
    output addr_t ram_a1,
    output data_t ram_wd1,
    output logic  ram_we1,
    output addr_t ram_a2,
    output data_t ram_wd2,
    output logic  ram_we2,
    input  data_t ram_dout2
);

    logic  w_push;
    logic  w_pop;
    logic  r_push_d1;
    addr_t w_wr_ptr;
    addr_t w_rd_ptr;
    lvl_t  w_vis_cnt;

    // Gated by rst_n so both handshakes are quiet for the whole reset pulse.
    assign wr_ready = rst_n & (level != lvl_t'(DEPTH));
    assign rd_valid = rst_n & (w_vis_cnt != '0);
    assign w_push   = wr_valid & wr_ready;
    assign w_pop    = rd_valid & rd_ready;

    dpram_fifo_ptr #(.PTR_ON_INC(1'b1)) u_wr_side (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (w_push),
        .dec   (w_pop),
        .ptr   (w_wr_ptr),
        .cnt   (level)
    );

    // A word only counts as readable once the RAM's registered write has landed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_push_d1 <= 1'b0;
        else        r_push_d1 <= w_push;
    end

    dpram_fifo_ptr #(.PTR_ON_INC(1'b0)) u_rd_side (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (r_push_d1),
        .dec   (w_pop),
        .ptr   (w_rd_ptr),
        .cnt   (w_vis_cnt)
    );

    assign ram_a1  = w_wr_ptr;
    assign ram_wd1 = wr_data;
    assign ram_we1 = w_push;
    // Read address is pre-advanced so the registered RAM address tracks rd_ptr.
    assign ram_a2  = w_rd_ptr + addr_t'(w_pop);
    assign ram_wd2 = '0;
    assign ram_we2 = 1'b0;
    assign rd_data = ram_dout2;

`ifdef DPRAM_FIFO_CTRL_ERR_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_err <= 1'b0;
            udf_err <= 1'b0;
        end else if (err_clr) begin
            ovf_err <= 1'b0;
            udf_err <= 1'b0;
        end else begin
            if (wr_valid && !wr_ready) ovf_err <= 1'b1;
            if (rd_ready && !rd_valid) udf_err <= 1'b1;
        end
    end
`endif

endmodule

`default_nettype wire
